// File: rtl/dig_pin_filter_cfg_ctrl.sv
// Configuration sequencer for a bank of digital pin filter channels.
// Each accepted request disables, flushes, reprograms and re-enables one channel.

module dig_pin_filter_cfg_lane #(
  parameter int LEN_W   = 8,
  parameter int RST_LEN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             sel,
  input  logic             dis,
  input  logic             fl_set,
  input  logic             fl_clr,
  input  logic             apply,
  input  logic [LEN_W-1:0] new_len,
  input  logic             new_dbl,
  input  logic             new_sync,
  input  logic             new_en,
  output logic             en,
  output logic             flush,
  output logic             dbl,
  output logic             sync,
  output logic [LEN_W-1:0] len
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en    <= 1'b0;
      flush <= 1'b0;
      dbl   <= 1'b1;
      sync  <= 1'b1;
      len   <= LEN_W'(RST_LEN);
    end else if (clr) begin
      en    <= 1'b0;
      flush <= 1'b0;
      dbl   <= 1'b1;
      sync  <= 1'b1;
      len   <= LEN_W'(RST_LEN);
    end else if (sel) begin
      if (dis)    en    <= 1'b0;
      if (fl_set) flush <= 1'b1;
      if (fl_clr) flush <= 1'b0;
      if (apply) begin
        en   <= new_en;
        dbl  <= new_dbl;
        sync <= new_sync;
        len  <= new_len;
      end
    end
  end
endmodule

module dig_pin_filter_cfg_ctrl #(
  parameter int N_CH      = 4,
  parameter int CH_W      = 2,
  parameter int LEN_W     = 8,
  parameter int FLUSH_CYC = 4,
  parameter int RST_LEN   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_clr_i,
  input  logic                  cfg_req_i,
  output logic                  cfg_ready_o,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [LEN_W-1:0]      cfg_len_i,
  input  logic                  cfg_dbl_i,
  input  logic                  cfg_sync_i,
  input  logic                  cfg_en_i,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic [N_CH-1:0]       filt_en_o,
  output logic [N_CH-1:0]       flush_o,
  output logic [N_CH-1:0]       filt_dbl_o,
  output logic [N_CH-1:0]       filt_sync_o,
  output logic [N_CH*LEN_W-1:0] filt_len_o
);
  localparam int CNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, APPLY, DONE} state_t;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [LEN_W-1:0] len;
    logic             dbl;
    logic             sync;
    logic             en;
  } cfg_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  cfg_t             pl;
  logic             acc, req_ok, acc_ok;
  logic [CH_W-1:0]  tgt;

  always_comb begin
    acc    = cfg_req_i & cfg_ready_o;
    req_ok = ({1'b0, cfg_ch_i} < (CH_W+1)'(N_CH)) && (cfg_len_i != '0);
    acc_ok = acc & req_ok;
    // While idle the only lane strobe is the disable at accept, which targets the incoming channel.
    tgt    = (st == IDLE) ? cfg_ch_i : pl.ch;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st <= IDLE; cnt <= '0; pl <= '0;
      cfg_ready_o <= 1'b1; cfg_done_o <= 1'b0; cfg_err_o <= 1'b0;
    end else if (sw_clr_i) begin
      st <= IDLE; cnt <= '0; pl <= '0;
      cfg_ready_o <= 1'b1; cfg_done_o <= 1'b0; cfg_err_o <= 1'b0;
    end else begin
      cfg_done_o <= 1'b0;
      cfg_err_o  <= 1'b0;
      case (st)
        IDLE: if (acc) begin
          if (req_ok) begin
            pl          <= '{ch: cfg_ch_i, len: cfg_len_i, dbl: cfg_dbl_i,
                             sync: cfg_sync_i, en: cfg_en_i};
            st          <= DRAIN;
            cfg_ready_o <= 1'b0;
          end else begin
            cfg_err_o <= 1'b1;
          end
        end
        DRAIN: begin
          st  <= FLUSH;
          cnt <= '0;
        end
        FLUSH: begin
          if (cnt == LAST) st  <= APPLY;
          else             cnt <= cnt + 1'b1;
        end
        APPLY: begin
          st         <= DONE;
          cfg_done_o <= 1'b1;
        end
        DONE: begin
          st          <= IDLE;
          cfg_ready_o <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  logic fl_set, fl_clr, apply;
  assign fl_set = (st == DRAIN);
  assign fl_clr = (st == FLUSH) && (cnt == LAST);
  assign apply  = (st == APPLY);

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    dig_pin_filter_cfg_lane #(.LEN_W(LEN_W), .RST_LEN(RST_LEN)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr     (sw_clr_i),
      .sel     (tgt == CH_W'(k)),
      .dis     (acc_ok),
      .fl_set  (fl_set),
      .fl_clr  (fl_clr),
      .apply   (apply),
      .new_len (pl.len),
      .new_dbl (pl.dbl),
      .new_sync(pl.sync),
      .new_en  (pl.en),
      .en      (filt_en_o[k]),
      .flush   (flush_o[k]),
      .dbl     (filt_dbl_o[k]),
      .sync    (filt_sync_o[k]),
      .len     (filt_len_o[k*LEN_W +: LEN_W])
    );
  end
endmodule
